// File: rtl/pc_sequencer_pkg.sv
// Shared types and constants for the PC sequencer: FSM states, reset/trap
// addresses and the fetch watchdog sizing.
package pc_seq_pkg;
    typedef enum logic [1:0] {ST_IDLE, ST_FETCH, ST_STALL, ST_HALT} state_e;

    localparam logic [31:0] RESET_PC    = 32'h0000_0000;
    localparam logic [31:0] TRAP_VECTOR = 32'h0000_0080;
    localparam int          WD_W        = 4;
    localparam logic [WD_W-1:0] TIMEOUT_LIMIT = 4'd15;
endpackage

// File: rtl/pc_sequencer_if.sv
// Instruction-memory fetch handshake: the sequencer drives request/address,
// memory answers with a single-cycle ack for the presented address.
interface pc_sequencer_if;
    logic        ImemReq;
    logic [31:0] ImemAddr;
    logic        ImemAck;

    modport master (output ImemReq, output ImemAddr, input ImemAck);
    modport slave  (input ImemReq, input ImemAddr, output ImemAck);
endinterface

// File: rtl/pc_next_mux.sv
// Combinational next-PC select: Jump > BranchTaken > PC+4 (wrapping).
// MISALIGN_TRAP_EN: misaligned targets go to TRAP_VECTOR and raise trap;
// otherwise target bits [1:0] are cleared and trap stays 0.
module pc_next_mux
    import pc_seq_pkg::*;
(
    input  logic [31:0] pc,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        redirect,
    output logic [31:0] next_pc,
    output logic        trap
);
    logic [31:0] target;
    logic [31:0] seq_pc;

    always_comb begin
        redirect = jump | branch_taken;
        target   = jump ? jump_target : branch_target;
        seq_pc   = pc + 32'd4;
        trap     = 1'b0;
`ifdef MISALIGN_TRAP_EN
        if (redirect && (target[1:0] != 2'b00)) begin
            trap   = 1'b1;
            target = TRAP_VECTOR;
        end
`else
        target[1:0] = 2'b00;
`endif
        next_pc = redirect ? target : seq_pc;
    end
endmodule

// File: rtl/pc_sequencer.sv
// Fetch-side PC sequencer: IDLE/FETCH/STALL/HALT FSM, PC register and fetch
// watchdog. Optional MISALIGN_TRAP_EN handling lives in pc_next_mux.
module pc_sequencer
    import pc_seq_pkg::*;
(
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Halt,
    input  logic        Stall,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    pc_sequencer_if.master imem,
    output logic [31:0] PC,
    output logic        FetchValid,
    output logic        Flush,
    output logic        Timeout,
    output logic        Trap
);
    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [WD_W-1:0]   wd_q, wd_d;
    logic              imem_req_q, imem_req_d;
    logic              fetch_valid_q, fetch_valid_d;
    logic              flush_q, flush_d;
    logic              timeout_q, timeout_d;
    logic              trap_q, trap_d;

    logic              redirect;
    logic [31:0]       next_pc;
    logic              trap;

    pc_next_mux u_next (
        .pc            (pc_q),
        .jump          (Jump),
        .jump_target   (JumpTarget),
        .branch_taken  (BranchTaken),
        .branch_target (BranchTarget),
        .redirect      (redirect),
        .next_pc       (next_pc),
        .trap          (trap)
    );

    // Priority inside active states: Halt > redirect > Stall > ack > watchdog.
    always_comb begin
        state_d       = state_q;
        pc_d          = pc_q;
        wd_d          = '0;
        fetch_valid_d = 1'b0;
        flush_d       = 1'b0;
        trap_d        = 1'b0;
        timeout_d     = timeout_q;
        case (state_q)
            ST_IDLE: if (Start) state_d = ST_FETCH;
            ST_FETCH: begin
                if (Halt) begin
                    state_d = ST_HALT;
                end else if (redirect) begin
                    pc_d    = next_pc;
                    flush_d = 1'b1;
                    trap_d  = trap;
                end else if (Stall) begin
                    state_d = ST_STALL;
                end else if (imem.ImemAck) begin
                    pc_d          = next_pc;
                    fetch_valid_d = 1'b1;
                end else begin
                    wd_d = wd_q + WD_W'(1);
                    if (wd_d == TIMEOUT_LIMIT) begin
                        timeout_d = 1'b1;
                        state_d   = ST_HALT;
                    end
                end
            end
            ST_STALL: begin
                if (Halt) begin
                    state_d = ST_HALT;
                end else if (redirect) begin
                    pc_d    = next_pc;
                    flush_d = 1'b1;
                    trap_d  = trap;
                    state_d = ST_FETCH;
                end else if (!Stall) begin
                    state_d = ST_FETCH;
                end
            end
            default: state_d = ST_HALT;
        endcase
        imem_req_d = (state_d == ST_FETCH);
    end

    always_ff @(posedge Clk) begin
        if (!Reset) begin
            state_q       <= ST_IDLE;
            pc_q          <= RESET_PC;
            wd_q          <= '0;
            imem_req_q    <= 1'b0;
            fetch_valid_q <= 1'b0;
            flush_q       <= 1'b0;
            timeout_q     <= 1'b0;
            trap_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            pc_q          <= pc_d;
            wd_q          <= wd_d;
            imem_req_q    <= imem_req_d;
            fetch_valid_q <= fetch_valid_d;
            flush_q       <= flush_d;
            timeout_q     <= timeout_d;
            trap_q        <= trap_d;
        end
    end

    assign imem.ImemReq  = imem_req_q;
    assign imem.ImemAddr = pc_q;
    assign PC            = pc_q;
    assign FetchValid    = fetch_valid_q;
    assign Flush         = flush_q;
    assign Timeout       = timeout_q;
    assign Trap          = trap_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed scenarios plus random
// stimulus against a behavioural fetch model. Honours MISALIGN_TRAP_EN.
module tb_pc_sequencer;
    logic        Clk = 1'b0;
    logic        Reset, Start, Halt, Stall, Jump, BranchTaken;
    logic [31:0] JumpTarget, BranchTarget;
    logic [31:0] PC;
    logic        FetchValid, Flush, Timeout, Trap;
    int          checks = 0;
    int          failures = 0;

    pc_sequencer_if imem ();

    pc_sequencer dut (
        .Clk(Clk), .Reset(Reset), .Start(Start), .Halt(Halt), .Stall(Stall),
        .Jump(Jump), .JumpTarget(JumpTarget), .BranchTaken(BranchTaken),
        .BranchTarget(BranchTarget), .imem(imem), .PC(PC),
        .FetchValid(FetchValid), .Flush(Flush), .Timeout(Timeout), .Trap(Trap)
    );

    always #5 Clk = ~Clk;

    // Behavioural model: what the fetch unit is doing, not how it is encoded.
    typedef enum {M_IDLE, M_RUN, M_STALLED, M_HALTED} mode_t;
    mode_t       m_mode;
    longint      m_pc;
    int          m_misses;
    bit          m_fv, m_flush, m_timeout, m_trap;

    function automatic longint target_addr();
        longint t;
        t = Jump ? longint'(JumpTarget) : longint'(BranchTarget);
        if (t % 4 != 0) begin
`ifdef MISALIGN_TRAP_EN
            return 128;
`else
            return t - (t % 4);
`endif
        end
        return t;
    endfunction

    function automatic bit target_traps();
        longint t;
        t = Jump ? longint'(JumpTarget) : longint'(BranchTarget);
`ifdef MISALIGN_TRAP_EN
        return (t % 4) != 0;
`else
        return (t % 4) != 0 && 1'b0;
`endif
    endfunction

    task automatic take_redirect();
        m_pc    = target_addr();
        m_trap  = target_traps();
        m_flush = 1;
        m_misses = 0;
        m_mode  = M_RUN;
    endtask

    task automatic model_edge();
        m_fv = 0; m_flush = 0; m_trap = 0;
        if (!Reset) begin
            m_mode = M_IDLE; m_pc = 0; m_misses = 0; m_timeout = 0;
        end else if (m_mode == M_IDLE) begin
            if (Start) m_mode = M_RUN;
        end else if (m_mode != M_HALTED && Halt) begin
            m_mode = M_HALTED; m_misses = 0;
        end else if (m_mode != M_HALTED && (Jump || BranchTaken)) begin
            take_redirect();
        end else if (m_mode == M_RUN) begin
            if (Stall) begin
                m_mode = M_STALLED; m_misses = 0;
            end else if (imem.ImemAck) begin
                m_fv = 1; m_pc = (m_pc + 4) % 64'h1_0000_0000; m_misses = 0;
            end else begin
                m_misses++;
                if (m_misses >= 15) begin
                    m_timeout = 1; m_mode = M_HALTED; m_misses = 0;
                end
            end
        end else if (m_mode == M_STALLED) begin
            if (!Stall) m_mode = M_RUN;
        end
    endtask

    function automatic logic [68:0] observed();
        return {imem.ImemReq, imem.ImemAddr, PC, FetchValid, Flush, Timeout, Trap};
    endfunction

    function automatic logic [68:0] expected();
        return {m_mode == M_RUN, m_pc[31:0], m_pc[31:0], m_fv, m_flush, m_timeout, m_trap};
    endfunction

    task automatic cyc();
        @(posedge Clk);
        model_edge();
        #1;
    endtask

    task automatic quiet();
        Reset = 1; Start = 0; Halt = 0; Stall = 0; Jump = 0; BranchTaken = 0;
        JumpTarget = 0; BranchTarget = 0; imem.ImemAck = 0;
    endtask

    task automatic do_reset();
        quiet(); Reset = 0; cyc(); Reset = 1;
    endtask

    task automatic test_reset();
        quiet();
        Reset = 0; Start = 1; Stall = 1; Jump = 1; JumpTarget = 32'h1234; imem.ImemAck = 1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++;
            if (observed() !== expected() || PC !== 32'h0) begin
                failures++;
                $display("FAIL reset_state got=%h want=%h", observed(), expected());
            end
        end
        quiet(); Start = 1; cyc(); Start = 0; cyc(); cyc();
        Reset = 0; imem.ImemAck = 1; cyc();
        checks++;
        if (observed() !== expected() || imem.ImemReq !== 1'b0 || FetchValid !== 1'b0) begin
            failures++;
            $display("FAIL reset_mid_fetch got=%h want=%h", observed(), expected());
        end
    endtask

    task automatic test_sequential();
        do_reset();
        Start = 1; cyc(); Start = 0;
        checks++;
        if (observed() !== expected() || PC !== 32'h0 || imem.ImemReq !== 1'b1) begin
            failures++;
            $display("FAIL seq_start got=%h want=%h", observed(), expected());
        end
        imem.ImemAck = 1;
        for (int i = 1; i <= 4; i++) begin
            cyc();
            checks++;
            if (observed() !== expected() || PC !== 32'(4 * i) || FetchValid !== 1'b1) begin
                failures++;
                $display("FAIL seq_fetch%0d got=%h want=%h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_priority();
        Jump = 1; JumpTarget = 32'h200; BranchTaken = 1; BranchTarget = 32'h300;
        imem.ImemAck = 1;
        cyc();
        checks++;
        if (observed() !== expected() || PC !== 32'h200 || Flush !== 1'b1 || FetchValid !== 1'b0) begin
            failures++;
            $display("FAIL priority got=%h want=%h", observed(), expected());
        end
        quiet(); cyc();
        checks++;
        if (observed() !== expected() || Flush !== 1'b0) begin
            failures++;
            $display("FAIL flush_pulse got=%h want=%h", observed(), expected());
        end
    endtask

    task automatic test_stall_wrap();
        Jump = 1; JumpTarget = 32'hFFFF_FFFC; cyc(); Jump = 0;
        Stall = 1; imem.ImemAck = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (observed() !== expected() || imem.ImemReq !== 1'b0 || PC !== 32'hFFFF_FFFC) begin
                failures++;
                $display("FAIL stall_hold%0d got=%h want=%h", i, observed(), expected());
            end
        end
        Stall = 0; imem.ImemAck = 0; cyc();
        checks++;
        if (observed() !== expected() || imem.ImemAddr !== 32'hFFFF_FFFC || imem.ImemReq !== 1'b1) begin
            failures++;
            $display("FAIL stall_release got=%h want=%h", observed(), expected());
        end
        imem.ImemAck = 1; cyc();
        checks++;
        if (observed() !== expected() || PC !== 32'h0) begin
            failures++;
            $display("FAIL pc_wrap got=%h want=%h", observed(), expected());
        end
        imem.ImemAck = 0;
    endtask

    task automatic test_misaligned();
        BranchTaken = 1; BranchTarget = 32'h42; cyc(); BranchTaken = 0;
        checks++;
`ifdef MISALIGN_TRAP_EN
        if (observed() !== expected() || PC !== 32'h80 || Trap !== 1'b1 || Flush !== 1'b1) begin
`else
        if (observed() !== expected() || PC !== 32'h40 || Trap !== 1'b0 || Flush !== 1'b1) begin
`endif
            failures++;
            $display("FAIL misaligned got=%h want=%h", observed(), expected());
        end
    endtask

    task automatic test_watchdog();
        do_reset();
        Start = 1; cyc(); Start = 0;
        for (int i = 1; i <= 15; i++) begin
            cyc();
            checks++;
            if (observed() !== expected() || Timeout !== (i == 15)) begin
                failures++;
                $display("FAIL watchdog%0d got=%h want=%h", i, observed(), expected());
            end
        end
        Start = 1; imem.ImemAck = 1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (observed() !== expected() || imem.ImemReq !== 1'b0 || Timeout !== 1'b1) begin
                failures++;
                $display("FAIL halt_sticky%0d got=%h want=%h", i, observed(), expected());
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] t;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            Reset        = ($urandom_range(0, 59) != 0);
            Start        = ($urandom_range(0, 3) == 0);
            Halt         = ($urandom_range(0, 79) == 0);
            Stall        = ($urandom_range(0, 3) == 0);
            Jump         = ($urandom_range(0, 9) == 0);
            BranchTaken  = ($urandom_range(0, 7) == 0);
            t = $urandom; if ($urandom_range(0, 1) == 1) t[1:0] = 2'b00;
            JumpTarget   = t;
            t = $urandom; if ($urandom_range(0, 1) == 1) t[1:0] = 2'b00;
            BranchTarget = t;
            imem.ImemAck = ($urandom_range(0, 5) > 1);
            cyc();
            checks++;
            if (observed() !== expected()) begin
                failures++;
                $display("FAIL random%0d got=%h want=%h", i, observed(), expected());
            end
        end
    endtask

    initial begin
        quiet();
        m_mode = M_IDLE; m_pc = 0; m_misses = 0;
        m_fv = 0; m_flush = 0; m_timeout = 0; m_trap = 0;
        test_reset();
        test_sequential();
        test_priority();
        test_stall_wrap();
        test_misaligned();
        test_watchdog();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
